register_pipe: RTL and testbench
================================

// Module: register_pipe
// PURPOSE
//   Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with
//   valid/ready handshake, global enable (freeze) and synchronous flush.
//   Next generation of the single 8-bit enable register: adds configurable width and depth,
//   back-pressure and bubble collapsing. Sits between datapath blocks to retime paths
//   without losing or duplicating data.
// PARAMETERS
//   WIDTH  8  data width in bits (>=1)
//   DEPTH  3  number of register stages (>=1); no-stall latency in cycles
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   enable     in   1      1: pipeline may advance; 0: freeze all stages
//   flush      in   1      synchronous clear of all stage valid bits
//   in_valid   in   1      upstream data valid
//   in_data    in   WIDTH  upstream data
//   in_ready   out  1      pipeline accepts in_data this cycle
//   out_valid  out  1      last stage holds valid data
//   out_data   out  WIDTH  last stage data
//   out_ready  in   1      downstream accepts out_data this cycle
//   count      out  $clog2(DEPTH+1)  occupied stages (only with REG_PIPE_COUNT_EN)
// BEHAVIOUR
//   - Reset (reset_n=0, async): all stage valid bits=0, all stage data=0; out_valid=0,
//     out_data=0, count=0. in_ready is combinational and reads 0 during reset.
//   - Stage k holds v[k], d[k]; stage 0 is input side, stage DEPTH-1 drives out_*.
//   - Advance condition adv[k]: stage k can load when enable=1 and (v[k]=0 or adv[k+1]);
//     adv[DEPTH] = out_ready. Ready chain is combinational (bubbles collapse same cycle).
//   - in_ready = adv[0]. Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready & enable.
//   - On clk edge with adv[k]=1: d[k] <= d[k-1] (in_data for k=0), v[k] <= v[k-1] (in_valid for k=0).
//     Data register only loads when the incoming valid is 1; on a bubble, data holds, v cleared.
//   - Latency: a word accepted in cycle N appears on out_* in cycle N+DEPTH if never stalled.
//   - Throughput: 1 word/cycle with out_ready=1 and enable=1.
//   - Full: all v=1 and out_ready=0 -> in_ready=0; no stage changes.
//   - Full with out_ready=1: simultaneous out and in transfer; occupancy unchanged.
//   - enable=0: in_ready=0, no register changes, out_valid/out_data held; out_ready ignored
//     (no out transfer counted). flush still acts.
//   - flush=1: all v <= 0 next edge, data unchanged; overrides same-cycle input acceptance
//     (in_ready still as computed, but the accepted word is discarded). Precedence: reset_n > flush > enable.
//   - Reset asserted mid-operation: contents lost immediately, no partial word emitted.
//   - No output changes except on clk edge or reset_n assertion; out_data stable while out_valid=1
//     and out_ready=0.
// CONFIGURATION
//   REG_PIPE_COUNT_EN defined: count port present; count = number of v[k]=1, updated each edge
//     (+1 on in transfer, -1 on out transfer, both -> unchanged, 0 on flush/reset).
//   REG_PIPE_COUNT_EN undefined: count port and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8, DEPTH=3)
//   1. reset_n=0 mid-stream with 3 words held -> out_valid=0, out_data=8'h00, count=0 at once.
//   2. enable=1, out_ready=1, push AA,55,FF back-to-back -> out AA,55,FF at cycles 3,4,5 after first push.
//   3. out_ready=0, push 4 words 11..14 -> 11,12,13 accepted, in_ready=0 on 4th; count=3;
//      release out_ready -> 11,12,13,14 in order, none lost or duplicated.
//   4. Pipe holding 2 words, enable=0 for 5 cycles with in_valid=1, out_ready=1 -> no change,
//      in_ready=0; enable=1 -> flow resumes in order.
//   5. Pipe holding 3 words, flush=1 with in_valid=1, in_data=8'h77 -> next cycle out_valid=0,
//      count=0, 8'h77 never emitted.
//   6. Random in_valid/out_ready (1000 cycles) vs scoreboard -> output sequence equals input sequence.

Source files
------------

// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with valid/ready flow control,
// global freeze (enable) and synchronous flush. Define REG_PIPE_COUNT_EN to add the occupancy port.
module register_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    // Handshake: a word moves across a boundary on a rising edge only when the sender's
    // valid and the receiver's ready are both 1 in that cycle. out_ready is ignored while
    // enable=0, and a flush discards everything held or accepted on that edge.

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] prev_v;
    logic [WIDTH-1:0] prev_d [DEPTH];
    logic             slack;

    // A stage may load if any stage at or after it is empty, or the output drains;
    // folding the chain into a running OR keeps bubble collapse a single combinational pass.
    always_comb begin
        slack = out_ready;
        adv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            slack  = slack | ~v[k];
            adv[k] = enable & slack;
        end
    end

    always_comb begin
        prev_v[0] = in_valid;
        prev_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            prev_v[k] = v[k-1];
            prev_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    v[k] <= 1'b0;
                end else if (adv[k]) begin
                    v[k] <= prev_v[k];
                    // Bubbles only clear the valid bit; data keeps its last word.
                    if (prev_v[k]) begin
                        d[k] <= prev_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0] & reset_n;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready & enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + 1'b1;
        end else if (out_xfer && !in_xfer) begin
            count <= count - 1'b1;
        end
    end
`endif

    out_data_held_a: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_data == $past(out_data)));

    frozen_not_ready_a: assert property (@(posedge clk) disable iff (!reset_n)
        in_ready |-> enable);

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe (WIDTH=8, DEPTH=3): directed scenarios plus a randomized run
// checked against a queue model of words in flight.
module tb_register_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef REG_PIPE_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    logic [WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef REG_PIPE_COUNT_EN
        ,
        .count     (count)
`endif
    );

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                         input logic en, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        enable    = en;
        flush     = fl;
        #1;
    endtask

    // Model: the queue holds every accepted word not yet delivered, oldest first.
    task automatic advance();
        logic rdy;
        rdy = enable && (exp_q.size() < DEPTH || out_ready);
        if (out_valid && out_ready && enable && exp_q.size() > 0) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_valid && rdy) exp_q.push_back(in_data);
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
`ifdef REG_PIPE_COUNT_EN
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] w[3];
        logic exp_v;
        w[0] = 8'hAA; w[1] = 8'h55; w[2] = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            drive(c < 3, (c < 3) ? w[c] : 8'h00, 1'b1, 1'b1, 1'b0);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready c%0d: got %b expected 1", c, in_ready); end
            exp_v = (c >= 3 && c <= 5);
            n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL latency_out_valid c%0d: got %b expected %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (out_data !== w[c-3]) begin n_fail++; $display("FAIL latency_out_data c%0d: got %h expected %h", c, out_data, w[c-3]); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] w[4];
        logic [WIDTH-1:0] got[$];
        logic sent;
        w[0] = 8'h11; w[1] = 8'h12; w[2] = 8'h13; w[3] = 8'h14;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b1, 1'b0);
            n_checks++; if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_in_ready word%0d: got %b expected %b", i, in_ready, (i < 3)); end
            advance();
        end
        drive(1'b1, w[3], 1'b0, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_head: got %b/%h expected 1/11", out_valid, out_data); end
`ifdef REG_PIPE_COUNT_EN
        n_checks++; if (count !== 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", count); end
`endif
        advance();
        sent = 1'b0;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            drive(!sent, w[3], 1'b1, 1'b1, 1'b0);
            if (!sent) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
            end
            sent = 1'b1;
            if (out_valid) got.push_back(out_data);
            advance();
        end
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== w[i]) begin n_fail++; $display("FAIL bp_order word%0d: got %h expected %h", i, got[i], w[i]); end
        end
    endtask

    task automatic test_freeze();
        logic [WIDTH-1:0] w[3];
        logic [WIDTH-1:0] got[$];
        w[0] = 8'h21; w[1] = 8'h22; w[2] = 8'h23;
        drive(1'b1, w[0], 1'b0, 1'b1, 1'b0); advance();
        drive(1'b1, w[1], 1'b0, 1'b1, 1'b0); advance();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); advance();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, w[2], 1'b1, 1'b0, 1'b0);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_in_ready c%0d: got %b expected 0", c, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_data !== w[0]) begin n_fail++; $display("FAIL freeze_out c%0d: got %b/%h expected 1/%h", c, out_valid, out_data, w[0]); end
`ifdef REG_PIPE_COUNT_EN
            n_checks++; if (count !== 2) begin n_fail++; $display("FAIL freeze_count c%0d: got %0d expected 2", c, count); end
`endif
            advance();
        end
        for (int c = 0; c < 15 && got.size() < 3; c++) begin
            drive(c == 0, w[2], 1'b1, 1'b1, 1'b0);
            if (c == 0) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL freeze_resume_in_ready: got %b expected 1", in_ready); end
            end
            if (out_valid) got.push_back(out_data);
            advance();
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL freeze_drain_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== w[i]) begin n_fail++; $display("FAIL freeze_order word%0d: got %h expected %h", i, got[i], w[i]); end
        end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] got[$];
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h31 + 8'(i), 1'b0, 1'b1, 1'b0); advance();
        end
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin n_fail++; $display("FAIL flush_head: got %b/%h expected 1/31", out_valid, out_data); end
        advance();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid c%0d: got %b data %h expected 0", c, out_valid, out_data); end
`ifdef REG_PIPE_COUNT_EN
            n_checks++; if (count !== 0) begin n_fail++; $display("FAIL flush_count c%0d: got %0d expected 0", c, count); end
`endif
            advance();
        end
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 8'h34, 1'b1, 1'b1, 1'b0);
            if (out_valid) got.push_back(out_data);
            advance();
        end
        n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL flush_after_count: got %0d expected 1", got.size()); end
        if (got.size() > 0) begin
            n_checks++; if (got[0] !== 8'h34) begin n_fail++; $display("FAIL flush_after_data: got %h expected 34", got[0]); end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h41 + 8'(i), 1'b0, 1'b1, 1'b0); advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_fail++; $display("FAIL midrst_head: got %b/%h expected 1/41", out_valid, out_data); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_out_data: got %h expected 00", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
`ifdef REG_PIPE_COUNT_EN
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
`endif
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after c%0d: got %b data %h expected 0", c, out_valid, out_data); end
            advance();
        end
    endtask

    task automatic test_random();
        logic iv, ordy, en, exp_rdy;
        logic [WIDTH-1:0] id;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            iv   = 1'($urandom_range(0, 1));
            id   = 8'($urandom_range(0, 255));
            ordy = ($urandom_range(0, 3) != 0);
            en   = ($urandom_range(0, 15) != 0);
            drive(iv, id, ordy, en, 1'b0);
            exp_rdy = en && (exp_q.size() < DEPTH || ordy);
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy); end
            if (exp_q.size() == 0) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_spurious cyc%0d: got valid %b data %h expected 0", cyc, out_valid, out_data); end
            end else if (out_valid === 1'b1) begin
                n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, out_data, exp_q[0]); end
            end
            if (exp_q.size() == DEPTH) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_full_valid cyc%0d: got %b expected 1", cyc, out_valid); end
            end
`ifdef REG_PIPE_COUNT_EN
            n_checks++; if (count !== exp_q.size()) begin n_fail++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", cyc, count, exp_q.size()); end
`endif
            advance();
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            if (out_valid === 1'b1) begin
                n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain_data: got %h expected %h", out_data, exp_q[0]); end
            end
            advance();
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_left: got %0d words undelivered expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_freeze();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
